// File: rtl/calc_pkg.sv
// calc_pkg: shared state codes, opcodes and operand width for the calculator core
package calc_pkg;
    localparam int CALC_N_BITS = 4;
    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } calc_state_t;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
endpackage

// File: rtl/calc_fsm_core_if.sv
// calc_fsm_core_if: switch/button entry and display/LED status bundle of the calculator core
interface calc_fsm_core_if #(parameter int N_BITS = calc_pkg::CALC_N_BITS);
    logic [N_BITS-1:0]   sw_in;
    logic                enter;
    logic [2*N_BITS-1:0] result;
    logic [N_BITS-1:0]   rem;
    logic                neg;
    logic                err;
    logic                busy;
    logic                done;
    logic [2:0]          state;
    modport master (output sw_in, enter, input result, rem, neg, err, busy, done, state);
    modport slave (input sw_in, enter, output result, rem, neg, err, busy, done, state);
endinterface

// File: rtl/calc_iter_unit.sv
// calc_iter_unit: iterative shift-add multiplier / restoring divider, one bit per cycle
module calc_iter_unit import calc_pkg::*; #(parameter int N_BITS = CALC_N_BITS) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                is_div,
    input  logic [N_BITS-1:0]   a,
    input  logic [N_BITS-1:0]   b,
    output logic                valid,
    output logic [2*N_BITS-1:0] prod_quot,
    output logic [N_BITS-1:0]   rem
);
    localparam int CW = $clog2(N_BITS);
    logic                run, div;
    logic [CW-1:0]       cnt;
    logic [2*N_BITS-1:0] acc, mc, acc_n;
    logic [N_BITS-1:0]   mp, dvs, pr, q, pr_n, q_n;
    logic [N_BITS:0]     sh, diff;
    // valid and the final step values are combinational so the caller can latch them on the last iteration edge
    always_comb begin
        acc_n     = acc + (mp[0] ? mc : '0);
        sh        = {pr, q[N_BITS-1]};
        diff      = sh - {1'b0, dvs};
        pr_n      = diff[N_BITS] ? sh[N_BITS-1:0] : diff[N_BITS-1:0];
        q_n       = {q[N_BITS-2:0], ~diff[N_BITS]};
        valid     = run && cnt == CW'(N_BITS - 1);
        prod_quot = div ? {{N_BITS{1'b0}}, q_n} : acc_n;
        rem       = div ? pr_n : '0;
    end
    always_ff @(posedge clk)
        if (reset) begin
            run <= 1'b0;
            div <= 1'b0;
            cnt <= '0;
            acc <= '0;
            mc  <= '0;
            mp  <= '0;
            dvs <= '0;
            pr  <= '0;
            q   <= '0;
        end else if (start) begin
            run <= 1'b1;
            div <= is_div;
            cnt <= '0;
            acc <= '0;
            mc  <= {{N_BITS{1'b0}}, a};
            mp  <= b;
            dvs <= b;
            pr  <= '0;
            q   <= a;
        end else if (run) begin
            run <= !valid;
            cnt <= cnt + 1'b1;
            acc <= acc_n;
            mc  <= mc << 1;
            mp  <= mp >> 1;
            pr  <= pr_n;
            q   <= q_n;
        end
endmodule

// File: rtl/calc_fsm_core.sv
// calc_fsm_core: operand/operator entry FSM with add/sub and iterative mul/div execution
module calc_fsm_core import calc_pkg::*; #(parameter int N_BITS = CALC_N_BITS) (
    input logic            clk,
    input logic            reset,
    calc_fsm_core_if.slave bus
);
    localparam int W = 2 * N_BITS;
    calc_state_t       state;
    logic              enter_q, enter_edge, start, iter, iu_valid, neg, err, busy, done;
    logic [N_BITS-1:0] a, b, rem, iu_rem;
    logic [1:0]        op;
    logic [W-1:0]      result, echo, alu, aw, bw, iu_pq;
    always_comb begin
        enter_edge = bus.enter & ~enter_q;
        echo       = {{N_BITS{1'b0}}, bus.sw_in};
        aw         = {{N_BITS{1'b0}}, a};
        bw         = {{N_BITS{1'b0}}, b};
        alu        = op == OP_ADD ? aw + bw : op == OP_SUB ? (a < b ? bw - aw : aw - bw) : '0;
        iter       = op == OP_MUL || (op == OP_DIV && b != '0);
        // launch on the LOAD_OP edge so EXEC spends exactly N_BITS cycles iterating
        start      = state == S_LOAD_OP && enter_edge
                     && (bus.sw_in[1:0] == OP_MUL || (bus.sw_in[1:0] == OP_DIV && b != '0));
    end
    calc_iter_unit #(.N_BITS(N_BITS)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_div    (bus.sw_in[0]),
        .a         (a),
        .b         (b),
        .valid     (iu_valid),
        .prod_quot (iu_pq),
        .rem       (iu_rem)
    );
    always_ff @(posedge clk)
        if (reset) begin
            state   <= S_LOAD_A;
            enter_q <= 1'b0;
            a       <= '0;
            b       <= '0;
            op      <= '0;
            result  <= '0;
            rem     <= '0;
            neg     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            enter_q <= bus.enter;
            case (state)
                S_LOAD_A, S_LOAD_B, S_LOAD_OP: begin
                    result <= echo;
                    if (enter_edge) begin
                        if (state == S_LOAD_A) a <= bus.sw_in;
                        if (state == S_LOAD_B) b <= bus.sw_in;
                        if (state == S_LOAD_OP) op <= bus.sw_in[1:0];
                        busy  <= state == S_LOAD_OP;
                        state <= state == S_LOAD_A ? S_LOAD_B : state == S_LOAD_B ? S_LOAD_OP : S_EXEC;
                    end
                end
                S_EXEC: if (!iter || iu_valid) begin
                    result <= iter ? iu_pq : alu;
                    rem    <= iter ? iu_rem : '0;
                    neg    <= op == OP_SUB && a < b;
                    err    <= op == OP_DIV && b == '0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_SHOW;
                end
                S_SHOW: if (enter_edge) begin
                    a      <= '0;
                    b      <= '0;
                    op     <= '0;
                    rem    <= '0;
                    neg    <= 1'b0;
                    err    <= 1'b0;
                    result <= echo;
                    done   <= 1'b0;
                    state  <= S_LOAD_A;
                end
                default: state <= S_LOAD_A;
            endcase
        end
    assign bus.result = result;
    assign bus.rem    = rem;
    assign bus.neg    = neg;
    assign bus.err    = err;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.state  = state;
endmodule

// File: tb/tb_calc_fsm_core.sv
// tb_calc_fsm_core: directed operations with a scoreboard checked on each rise of done
module tb_calc_fsm_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    calc_fsm_core_if bus ();
    calc_fsm_core dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic [3:0] rem;
        logic       neg;
        logic       err;
        int         cyc;
    } exp_t;
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   bcnt = 0;
    logic done_q = 1'b0;
    exp_t me;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] v);
        bus.sw_in = v;
        bus.enter = 1'b1;
        @(negedge clk);
        bus.enter = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
        chk("done_reached", bus.done, 1);
    endtask

    task automatic back_to_a();
        press(4'd10);
        chk("ret_state", bus.state, 0);
        chk("ret_echo", bus.result, 10);
        chk("ret_flags", {bus.rem, bus.neg, bus.err, bus.done}, 0);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] opc,
                          input logic [7:0] res, input logic [3:0] r, input logic n,
                          input logic er, input int cyc, input bit poke);
        exp_t e;
        e.res = res; e.rem = r; e.neg = n; e.err = er; e.cyc = cyc;
        sb.push_back(e);
        press(a);
        press(b);
        press({2'b00, opc});
        if (poke) begin
            @(negedge clk);
            bus.enter = 1'b1;
            @(negedge clk);
            bus.enter = 1'b0;
        end
        wait_done();
        back_to_a();
    endtask

    // monitor: compare outputs against the scoreboard whenever SHOW is entered
    initial forever begin
        @(negedge clk);
        if (bus.done && !done_q) begin
            chk("sb_nonempty", sb.size(), 1);
            if (sb.size() > 0) begin
                me = sb.pop_front();
                chk("result", bus.result, me.res);
                chk("rem", bus.rem, me.rem);
                chk("neg", bus.neg, me.neg);
                chk("err", bus.err, me.err);
                chk("busy_cycles", bcnt, me.cyc);
            end
        end
        done_q = bus.done;
        bcnt = bus.busy ? bcnt + 1 : 0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sw_in = 4'd0;
        bus.enter = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_state", bus.state, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_rem", bus.rem, 0);
        chk("rst_neg", bus.neg, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        run_op(4'd7, 4'd9, 2'b00, 8'd16, 4'd0, 1'b0, 1'b0, 1, 1'b0);
        run_op(4'd3, 4'd12, 2'b01, 8'd9, 4'd0, 1'b1, 1'b0, 1, 1'b0);
        run_op(4'd12, 4'd3, 2'b01, 8'd9, 4'd0, 1'b0, 1'b0, 1, 1'b0);
        run_op(4'd15, 4'd15, 2'b10, 8'd225, 4'd0, 1'b0, 1'b0, 4, 1'b1);
        run_op(4'd13, 4'd4, 2'b11, 8'd3, 4'd1, 1'b0, 1'b0, 4, 1'b0);
        run_op(4'd5, 4'd0, 2'b11, 8'd0, 4'd0, 1'b0, 1'b1, 1, 1'b0);
        bus.sw_in = 4'd6;
        bus.enter = 1'b1;
        repeat (10) @(negedge clk);
        chk("hold_single_advance", bus.state, 1);
        bus.enter = 1'b0;
        @(negedge clk);
        me.res = 8'd8; me.rem = 4'd0; me.neg = 1'b0; me.err = 1'b0; me.cyc = 1;
        sb.push_back(me);
        press(4'd2);
        press(4'd0);
        wait_done();
        back_to_a();
        press(4'd15);
        press(4'd15);
        press(4'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midexec_rst_state", bus.state, 0);
        chk("midexec_rst_result", bus.result, 0);
        chk("midexec_rst_busy", bus.busy, 0);
        reset = 1'b0;
        @(negedge clk);
        run_op(4'd9, 4'd2, 2'b11, 8'd4, 4'd1, 1'b0, 1'b0, 4, 1'b0);
        run_op(4'd7, 4'd6, 2'b10, 8'd42, 4'd0, 1'b0, 1'b0, 4, 1'b0);
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/calc_fsm_core.md
# calc_fsm_core

Operand-entry and arithmetic controller for the FSM-controlled 4-bit calculator. It sequences operand A, operand B and operator entry from four switches and one debounced Enter button, then executes add, subtract, multiply or divide. Multiply and divide run iteratively. It drives the unsigned 8-bit value that the downstream binary-to-3-digit seven-segment decoder consumes directly, plus status flags for LEDs.

## Interface
Parameters:
- `N_BITS`, default 4: operand width. Result width is 2*N_BITS; iteration count is N_BITS.

Ports:
- `clk`, in, 1: single system clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `sw_in`, in, 4: operand value in LOAD_A/LOAD_B; opcode in LOAD_OP (`sw_in[1:0]`: 00 add, 01 sub, 10 mul, 11 div).
- `enter`, in, 1: debounced level from the Enter button; only its rising edge acts.
- `result`, out, 8: unsigned value sent to the display decoder.
- `rem`, out, 4: remainder of the last divide; 0 otherwise.
- `neg`, out, 1: last subtract result was negative; `result` holds the magnitude.
- `err`, out, 1: divide by zero.
- `busy`, out, 1: high while in EXEC.
- `done`, out, 1: high while in SHOW.
- `state`, out, 3: current state code, for debug LEDs.

## Operation
- Edge detect: `enter_q` register; `enter_edge = enter & ~enter_q`. Holding `enter` high yields exactly one edge.
- States and transitions:
  - LOAD_A → LOAD_B on edge; latches A.
  - LOAD_B → LOAD_OP on edge; latches B.
  - LOAD_OP → EXEC on edge; latches op.
  - EXEC → SHOW when the computation completes.
  - SHOW → LOAD_A on edge; on that edge A, B, op, `rem`, `neg` and `err` clear to 0.
- In LOAD_A, LOAD_B and LOAD_OP, `result` is registered `{4'b0, sw_in}`, so the user sees live entry.
- Add: result = A + B, 0..30.
- Sub: if A ≥ B, result = A − B and `neg` = 0; else result = B − A and `neg` = 1.
- Mul: shift-add, one partial product per cycle, N_BITS cycles. Maximum 15*15 = 225, which fits in 8 bits with no overflow.
- Div: restoring division, one quotient bit per cycle, N_BITS cycles. result = quotient zero-extended; `rem` = remainder.
- Div with B = 0: no iteration. `err` = 1, result = 0, `rem` = 0, then SHOW.
- Enter edges in EXEC are discarded; `enter_q` still tracks `enter`.
- Reset at any time, including mid-EXEC, aborts any computation with no partial result visible. After the reset edge the block is in LOAD_A, `result` = 0, all flags 0, and the iteration counter is 0.

## Timing
- Reset values:
  - `state` = LOAD_A (3'd0); other codes are LOAD_B 1, LOAD_OP 2, EXEC 3, SHOW 4.
  - `result` = 0, `rem` = 0, `neg` = 0, `err` = 0, `busy` = 0, `done` = 0, `enter_q` = 0.
- Entry echo: `result` follows `sw_in` one cycle late.
- State change takes effect on the same clock edge where `enter_edge` is 1.
- EXEC duration:
  - Add, sub and div-by-zero: 1 cycle.
  - Mul and div: N_BITS = 4 cycles.
  - `result` is written on the edge that leaves EXEC; `done` rises in the same cycle.
- `result` stays frozen throughout EXEC at the last LOAD_OP echo value, and throughout SHOW.
- Outputs are registered only; no combinational path from inputs to outputs.

## Structure
- Shared package `calc_pkg`:
  - state enum/localparams (LOAD_A..SHOW)
  - opcode constants OP_ADD/SUB/MUL/DIV
  - `CALC_N_BITS` = 4
- Sub-module `calc_iter_unit`, natural for the sequential part:
  - Owns the shift-add multiplier and restoring divider datapath plus its 2-bit iteration counter.
  - Handshake: `start` pulse in; `valid` pulse out with `prod_quot[7:0]` and `rem[3:0]`.
  - Same `clk` and synchronous `reset`.
- Top FSM handles edge detection, latching, add/sub, flags and output registers.

## Test plan
- Reset held 2 cycles, then released → `state` = 0, `result` = 0, `rem`/`neg`/`err`/`busy`/`done` = 0.
- A = 7, B = 9, op = 00 → `busy` for 1 cycle, then SHOW with `result` = 16, `neg` = 0, `done` = 1. Next Enter → LOAD_A, `result` = `sw_in`.
- A = 3, B = 12, op = 01 → `result` = 9, `neg` = 1. Also A = 12, B = 3 → `result` = 9, `neg` = 0.
- A = 15, B = 15, op = 10 → `busy` exactly 4 cycles, `result` = 225. An Enter edge pulsed mid-EXEC is ignored; SHOW is reached normally.
- Divide cases:
  - A = 13, B = 4, op = 11 → `result` = 3, `rem` = 1 after 4 busy cycles.
  - A = 5, B = 0, op = 11 → `err` = 1, `result` = 0 after 1 busy cycle.
- `enter` held high for 10 cycles in LOAD_A → only a single advance to LOAD_B. Separately, `reset` asserted in the 2nd EXEC cycle of a multiply → next cycle `state` = LOAD_A, `result` = 0, `busy` = 0.
